neander_sequencer: RTL
======================

Name: neander_sequencer

Overview:
- Instruction-cycle controller for the 8-bit Neander datapath (PC, REM, RI, AC/ALU, N/Z flags, byte memory).
- Latches the opcode, steps fetch/decode/operand/execute, and drives every datapath enable and mux select.
- Handshakes with memory via mem_ready, supports run/single-step, and enforces a bounded wait timeout that halts with bus_err.

Parameters:
WAIT_LIMIT, 15, max stalled cycles tolerated per memory access (0 = timeout disabled)
CNT_W, 4, width of wait counter; must hold WAIT_LIMIT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = fetch next instruction at each boundary
step  in  1  one-cycle pulse; executes one instruction when idle
mem_ready  in  1  current memory read/write completes this cycle
mem_data  in  8  memory read data; opcode = mem_data[7:4]
flag_n  in  1  AC negative flag
flag_z  in  1  AC zero flag
sel_mem  out  1  memory address select: 1 = PC, 0 = REM
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request (data = AC)
en_rem  out  1  REM <- mem_data
en_ri  out  1  RI <- mem_data
en_pc  out  1  PC load enable
sel_pc  out  1  PC source: 1 = PC+1, 0 = mem_data
en_ac  out  1  AC <- ALU result
en_nz  out  1  N/Z flags update
op_alu  out  3  000 pass B, 001 ADD, 010 OR, 011 AND, 100 NOT A
instr_done  out  1  asserted in final cycle of each instruction
halted  out  1  registered; 1 in HALT
bus_err  out  1  registered, sticky; memory timeout occurred
state  out  3  registered state code

Behaviour:
- Reset: state=IDLE(0), opcode reg=0, wait counter=0, halted=0, bus_err=0. All combinational outputs are 0 in IDLE. Reset aborts any in-flight access with no write.
- Control outputs are combinational from state, opcode, flags, and mem_ready. Any output not listed for a state is 0, and op_alu=000.
- Opcodes: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 8 JMP, 9 JN, A JZ, F HLT. Codes 7, B–E execute as NOP.
- "Boundary" = next state is FETCH if run=1, else IDLE. instr_done=1 on that cycle.
- IDLE(0): run=1 or step=1 -> FETCH. step is ignored in every other state and is not queued.
- FETCH(1): sel_mem=1, mem_rd=1. On mem_ready: en_ri=1, en_pc=1, sel_pc=1, opcode reg <= mem_data[7:4], -> DECODE.
- DECODE(2):
  - NOP/undefined -> boundary.
  - NOT: en_ac=1, en_nz=1, op_alu=100 -> boundary.
  - HLT -> HALT.
  - 1–5 -> OPER.
  - JMP, JN with flag_n=1, JZ with flag_z=1 -> OPER.
  - Untaken JN/JZ -> SKIP.
- OPER(3): sel_mem=1, mem_rd=1. On mem_ready:
  - Jump: en_pc=1, sel_pc=0 -> boundary.
  - Otherwise: en_rem=1, en_pc=1, sel_pc=1 -> EXEC.
- SKIP(4): en_pc=1, sel_pc=1 -> boundary (no memory access).
- EXEC(5): sel_mem=0.
  - STA: mem_wr=1 held until mem_ready.
  - LDA/ADD/OR/AND: mem_rd=1. On mem_ready: en_ac=1, en_nz=1, op_alu=000/001/010/011.
  - On mem_ready -> boundary.
- HALT(7): halted=1, all enables 0. Exit only via reset.
- Flags are sampled in DECODE only.
- Wait counter:
  - Clears on each state entry and on mem_ready.
  - Increments each FETCH/OPER/EXEC cycle with mem_ready=0.
  - If WAIT_LIMIT≠0, counter==WAIT_LIMIT and mem_ready=0: -> HALT and bus_err<=1. No enable pulses that cycle.
  - mem_ready on the counter==WAIT_LIMIT cycle is accepted normally.
- Latency with mem_ready=1: NOP/NOT 2 cycles; JMP, taken and untaken branches 3; STA/LDA/ADD/OR/AND 4; HLT reaches HALT after 2.
- run deasserted mid-instruction: the instruction completes, then -> IDLE.

Test Plan:
- Reset, run=1, mem_ready=1, memory {0:20 1:80 2:30 3:81 4:10 5:82 6:F0}, 80=05, 81=03 -> 82=08; HALT at cycle 14; halted=1; instr_done pulses 3 times.
- AC=0 (flag_z=1): JZ 0x40 taken -> PC=0x40 after 3 cycles; flag_z=0 -> SKIP, PC=prev+2, no OPER read.
- run=0, step pulses each 10 cycles -> exactly one instruction per pulse, IDLE between. A step held during EXEC is ignored.
- LDA with mem_ready delayed 3 cycles in EXEC -> mem_rd held 4 cycles; en_ac single pulse on the ready cycle; total 7 cycles.
- WAIT_LIMIT=15, mem_ready stuck 0 in FETCH -> after 16 stalled cycles state=7, bus_err=1, no en_* pulses. Reset clears bus_err. With WAIT_LIMIT=0 it stalls forever.
- Reset asserted during STA EXEC wait -> next cycle state=0, mem_wr=0, memory unchanged. Opcode 0xC0 -> 2-cycle NOP.

Source files
------------

// File: rtl/neander_sequencer_if.sv
// Control and memory bus between the Neander sequencer and its datapath.
// master = sequencer side, slave = datapath/memory side.
interface neander_sequencer_if;
   logic       mem_ready;
   logic [7:0] mem_data;
   logic       flag_n;
   logic       flag_z;
   logic       sel_mem;
   logic       mem_rd;
   logic       mem_wr;
   logic       en_rem;
   logic       en_ri;
   logic       en_pc;
   logic       sel_pc;
   logic       en_ac;
   logic       en_nz;
   logic [2:0] op_alu;

   modport master (
      input  mem_ready, mem_data, flag_n, flag_z,
      output sel_mem, mem_rd, mem_wr, en_rem, en_ri, en_pc, sel_pc, en_ac, en_nz, op_alu
   );

   modport slave (
      output mem_ready, mem_data, flag_n, flag_z,
      input  sel_mem, mem_rd, mem_wr, en_rem, en_ri, en_pc, sel_pc, en_ac, en_nz, op_alu
   );
endinterface

// File: rtl/neander_sequencer.sv
// Instruction-cycle controller for the 8-bit Neander datapath: fetch/decode/operand/execute
// with a memory ready handshake, run/single-step control and a bounded memory wait timeout.
module neander_sequencer #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_run,
   input  logic                i_step,
   neander_sequencer_if.master bus,
   output logic                o_instr_done,
   output logic                o_halted,
   output logic                o_bus_err,
   output logic [2:0]          o_state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_OPER   = 3'd3;
   localparam logic [2:0] S_SKIP   = 3'd4;
   localparam logic [2:0] S_EXEC   = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd7;

   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_NOT = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JN  = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

   logic [2:0]       r_state;
   logic [3:0]       r_opcode;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_halted;
   logic             r_bus_err;

   logic [2:0] w_next_state;
   logic [2:0] w_boundary;
   logic       w_load_op;
   logic       w_mem_phase;
   logic       w_timeout;
   logic       w_jump;
   logic       w_unused;

   assign w_boundary  = i_run ? S_FETCH : S_IDLE;
   assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_OPER) || (r_state == S_EXEC);
   assign w_timeout   = (WAIT_LIMIT != 0) && w_mem_phase && !bus.mem_ready &&
                        (r_wait_cnt == LIMIT);
   assign w_jump      = (r_opcode == OP_JMP) || (r_opcode == OP_JN) || (r_opcode == OP_JZ);
   assign w_unused    = ^bus.mem_data[3:0];

   always_comb begin
      bus.sel_mem  = 1'b0;
      bus.mem_rd   = 1'b0;
      bus.mem_wr   = 1'b0;
      bus.en_rem   = 1'b0;
      bus.en_ri    = 1'b0;
      bus.en_pc    = 1'b0;
      bus.sel_pc   = 1'b0;
      bus.en_ac    = 1'b0;
      bus.en_nz    = 1'b0;
      bus.op_alu   = 3'b000;
      o_instr_done = 1'b0;
      w_load_op    = 1'b0;
      w_next_state = r_state;

      case (r_state)
         S_IDLE: begin
            if (i_run || i_step) w_next_state = S_FETCH;
         end
         S_FETCH: begin
            bus.sel_mem = 1'b1;
            bus.mem_rd  = 1'b1;
            if (w_timeout) begin
               w_next_state = S_HALT;
            end else if (bus.mem_ready) begin
               bus.en_ri    = 1'b1;
               bus.en_pc    = 1'b1;
               bus.sel_pc   = 1'b1;
               w_load_op    = 1'b1;
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            case (r_opcode)
               OP_NOT: begin
                  bus.en_ac    = 1'b1;
                  bus.en_nz    = 1'b1;
                  bus.op_alu   = 3'b100;
                  o_instr_done = 1'b1;
                  w_next_state = w_boundary;
               end
               OP_HLT: w_next_state = S_HALT;
               OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: w_next_state = S_OPER;
               OP_JN:  w_next_state = bus.flag_n ? S_OPER : S_SKIP;
               OP_JZ:  w_next_state = bus.flag_z ? S_OPER : S_SKIP;
               default: begin
                  o_instr_done = 1'b1;
                  w_next_state = w_boundary;
               end
            endcase
         end
         S_OPER: begin
            bus.sel_mem = 1'b1;
            bus.mem_rd  = 1'b1;
            if (w_timeout) begin
               w_next_state = S_HALT;
            end else if (bus.mem_ready) begin
               bus.en_pc = 1'b1;
               if (w_jump) begin
                  o_instr_done = 1'b1;
                  w_next_state = w_boundary;
               end else begin
                  bus.en_rem   = 1'b1;
                  bus.sel_pc   = 1'b1;
                  w_next_state = S_EXEC;
               end
            end
         end
         S_SKIP: begin
            bus.en_pc    = 1'b1;
            bus.sel_pc   = 1'b1;
            o_instr_done = 1'b1;
            w_next_state = w_boundary;
         end
         S_EXEC: begin
            // REM addresses memory here; STA writes AC, every other opcode reads
            if (r_opcode == OP_STA) bus.mem_wr = 1'b1;
            else                    bus.mem_rd = 1'b1;
            if (w_timeout) begin
               w_next_state = S_HALT;
            end else if (bus.mem_ready) begin
               if (r_opcode != OP_STA) begin
                  bus.en_ac = 1'b1;
                  bus.en_nz = 1'b1;
                  case (r_opcode)
                     OP_ADD:  bus.op_alu = 3'b001;
                     OP_OR:   bus.op_alu = 3'b010;
                     OP_AND:  bus.op_alu = 3'b011;
                     default: bus.op_alu = 3'b000;
                  endcase
               end
               o_instr_done = 1'b1;
               w_next_state = w_boundary;
            end
         end
         S_HALT: w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_opcode   <= 4'h0;
         r_wait_cnt <= '0;
         r_halted   <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_halted <= (w_next_state == S_HALT);
         if (w_load_op) r_opcode <= bus.mem_data[7:4];
         // Counter measures stall length of the current access only
         if ((w_next_state != r_state) || bus.mem_ready) r_wait_cnt <= '0;
         else if (w_mem_phase)                           r_wait_cnt <= r_wait_cnt + 1'b1;
         if (w_timeout) r_bus_err <= 1'b1;
      end
   end

   assign o_state   = r_state;
   assign o_halted  = r_halted;
   assign o_bus_err = r_bus_err;

endmodule
